tetris_grid_store: RTL
======================

Name: tetris_grid_store

Overview:
Playfield memory responder for the grid controller. It holds ROWS x COLS occupancy bits and serves row reads, whose data returns on the controller's grid input. It accepts row writes, whose data comes from the controller's grid output. On request, it autonomously detects full rows, removes them and compacts the rows above downward.

Parameters:
ROWS, 16, number of playfield rows; row 0 is the top row.
COLS, 8, cells per row; one bit per cell, 1 = occupied.
ADDR_W, 4, row address width; must satisfy 2**ADDR_W >= ROWS.
CNT_W, 5, width of the cleared-row counter; must hold ROWS.

Ports:
clock  in  1  system clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset.
row_addr  in  ADDR_W  row selected for read and write.
wr_en  in  1  write row_addr with wr_data this cycle.
wr_data  in  COLS  row write data, driven by the controller's tetrisGridOut.
rd_data  out  COLS  registered read data, feeding the controller's tetrisGridIn.
clear_req  in  1  single-cycle request to start a full-row clear pass.
busy  out  1  high while a clear pass is in progress.
clear_done  out  1  one-cycle pulse at the end of a pass.
cleared_count  out  CNT_W  rows removed by the last pass; held until the next pass.
full_row_mask  out  ROWS  combinational from the array; bit r = row r all ones.
lines_total  out  16  running cleared-line total (see Optional Feature).

Behaviour:
- Reset (async, reset=0): all array rows = 0; FSM = IDLE; rd_data, cleared_count and lines_total = 0; busy and clear_done = 0; scan pointer = ROWS-1.
- Read:
  - rd_data <= row[row_addr] on every edge, so data arrives 1 cycle after the address is presented.
  - row_addr >= ROWS returns 0.
  - A read and write to the same row in the same cycle returns the old data.
  - Reads are allowed in every state and return live array contents, which may be mid-shift.
- Write:
  - Honoured only in IDLE with row_addr < ROWS.
  - Writes in other states or to out-of-range addresses are silently dropped.
- full_row_mask reflects a write from the cycle after it.
- FSM states: IDLE, SCAN, SHIFT, DONE.
- IDLE:
  - clear_req=1: ptr <= ROWS-1, count <= 0, go to SCAN.
  - A write in the same cycle as clear_req is committed first, so the scan sees it.
  - clear_req outside IDLE is ignored and not queued.
- SCAN, one row per cycle:
  - row[ptr] full: count++, k <= ptr, go to SHIFT.
  - Else if ptr == 0: go to DONE.
  - Else: ptr--.
- SHIFT, one row per cycle:
  - k > 0: row[k] <= row[k-1], k--.
  - k == 0: row[0] <= 0, return to SCAN with ptr unchanged. The row shifted into ptr may itself be full.
  - A full row at ptr p costs p+1 SHIFT cycles.
- DONE:
  - clear_done = 1 for this one cycle.
  - cleared_count <= count.
  - Go to IDLE.
- busy = 1 in SCAN, SHIFT and DONE; 0 in IDLE.
- A pass with no full rows costs ROWS SCAN cycles plus 1 DONE cycle. cleared_count = 0 and clear_done still pulses.
- An all-full grid terminates with cleared_count = ROWS and all rows zero.
- Reset asserted mid-pass aborts immediately to the reset state. A partially compacted array is discarded.

Optional Feature:
GRID_SCORE_EN:
- Defined: lines_total accumulates count at each DONE, saturating at 16'hFFFF; it is cleared only by reset.
- Undefined: lines_total is tied to 0 and no accumulator is built.

Test Plan:
- Read/write latency: reset, write row 5 = 8'hA5 in IDLE, then present row_addr=5 -> rd_data=8'hA5 exactly 1 cycle later. row_addr=15 without a prior write -> 8'h00.
- Dropped writes: row_addr=4'hF with ROWS=12 -> write dropped, rd_data=0. A write during busy -> array unchanged after the pass.
- Single clear:
  - Setup: row15=8'hFF, row14=8'h81, row13=8'h3C, then clear_req.
  - Expect busy for 34 cycles (1+16+16+1) and clear_done pulse in the last cycle.
  - Expect row15=8'h81, row14=8'h3C, row0=0, cleared_count=1.
- Double clear:
  - Setup: rows 14 and 15 = 8'hFF, row13=8'h18.
  - Expect 51 busy cycles, row15=8'h18, rows 0-14 = 0, cleared_count=2.
  - With GRID_SCORE_EN, lines_total=2 after this pass, and 3 after a further single clear.
- No-op pass and ignored request: empty grid, clear_req -> 17 busy cycles, cleared_count=0, clear_done pulses once. A clear_req during busy does not start a second pass.
- Reset mid-pass: assert reset in SHIFT -> busy=0 and rd_data=0 immediately. After release, every row reads 8'h00 and full_row_mask=0.

Source files
------------

// File: rtl/tetris_grid_store.sv
// Playfield occupancy memory: registered row reads, IDLE-only row writes, and an autonomous
// full-row clear pass that compacts rows downward. Define GRID_SCORE_EN to build the lines_total accumulator.
module tetris_grid_store #(
  parameter int ROWS   = 16,
  parameter int COLS   = 8,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] row_addr,
  input  logic              wr_en,
  input  logic [COLS-1:0]   wr_data,
  output logic [COLS-1:0]   rd_data,
  input  logic              clear_req,
  output logic              busy,
  output logic              clear_done,
  output logic [CNT_W-1:0]  cleared_count,
  output logic [ROWS-1:0]   full_row_mask,
  output logic [15:0]       lines_total,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, SHIFT = 2'd2, DONE = 2'd3} state_e;

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

  state_e             state_q, state_d;
  logic [COLS-1:0]    grid_q [ROWS];
  logic [COLS-1:0]    grid_d [ROWS];
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [ADDR_W-1:0]  k_q, k_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [COLS-1:0]    rd_data_q, rd_data_d;
  logic [CNT_W-1:0]   cleared_count_q, cleared_count_d;

  always_comb begin
    for (int r = 0; r < ROWS; r++) full_row_mask[r] = &grid_q[r];
  end

  // Address decode by comparison keeps out-of-range addresses from touching the array.
  always_comb begin
    state_d         = state_q;
    grid_d          = grid_q;
    ptr_d           = ptr_q;
    k_d             = k_q;
    count_d         = count_q;
    cleared_count_d = cleared_count_q;
    rd_data_d       = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (row_addr == ADDR_W'(r)) rd_data_d = grid_q[r];
      if (state_q == IDLE && wr_en && row_addr == ADDR_W'(r)) grid_d[r] = wr_data;
    end
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          ptr_d   = LAST_ROW;
          count_d = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (full_row_mask[ptr_q]) begin
          count_d = count_q + CNT_W'(1);
          k_d     = ptr_q;
          state_d = SHIFT;
        end else if (ptr_q == '0) begin
          state_d = DONE;
        end else begin
          ptr_d = ptr_q - ADDR_W'(1);
        end
      end
      SHIFT: begin
        // ptr stays put: the row shifted into it must be rescanned.
        if (k_q == '0) begin
          grid_d[0] = '0;
          state_d   = SCAN;
        end else begin
          for (int r = 1; r < ROWS; r++) begin
            if (k_q == ADDR_W'(r)) grid_d[r] = grid_q[r-1];
          end
          k_d = k_q - ADDR_W'(1);
        end
      end
      DONE: begin
        cleared_count_d = count_q;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      for (int r = 0; r < ROWS; r++) grid_q[r] <= '0;
      ptr_q           <= LAST_ROW;
      k_q             <= '0;
      count_q         <= '0;
      rd_data_q       <= '0;
      cleared_count_q <= '0;
    end else begin
      state_q         <= state_d;
      grid_q          <= grid_d;
      ptr_q           <= ptr_d;
      k_q             <= k_d;
      count_q         <= count_d;
      rd_data_q       <= rd_data_d;
      cleared_count_q <= cleared_count_d;
    end
  end

`ifdef GRID_SCORE_EN
  logic [15:0] lines_total_q, lines_total_d;
  logic [16:0] lines_sum;

  always_comb begin
    lines_sum     = {1'b0, lines_total_q} + 17'(count_q);
    lines_total_d = lines_total_q;
    if (state_q == DONE) lines_total_d = lines_sum[16] ? 16'hFFFF : lines_sum[15:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) lines_total_q <= '0;
    else        lines_total_q <= lines_total_d;
  end

  assign lines_total = lines_total_q;
`else
  assign lines_total = '0;
`endif

  assign rd_data       = rd_data_q;
  assign cleared_count = cleared_count_q;
  assign busy          = (state_q != IDLE);
  assign clear_done    = (state_q == DONE);
  assign dbg_state     = state_q;

endmodule
